rom_fetch_arbiter: RTL and testbench
====================================

// Module: rom_fetch_arbiter
// PURPOSE
//  Shares the single combinational 32-bit instruction ROM read port between the core's
//  instruction-fetch port (IF) and a data-read port (DP: ROM constant loads, debug).
//  Arbitrates per cycle, drives the ROM address from a register and returns
//  registered read data with an owner-steered rvalid. Flags misaligned word requests.
//  Sits between the fetch stage / LSU and the ROM instance.
// PARAMETERS
//  BITS_ADDR   8  ROM byte-address width; matches the ROM instance.
//  STARVE_MAX  4  Consecutive DP losses before DP wins the next conflict; range 1..15.
//  CHECK_ALIGN 1  1: addr[1:0]!=0 is an error. 0: misaligned addresses pass to the ROM.
// PORTS
//  clk        in   1          Rising-edge clock.
//  rst_n      in   1          Asynchronous active-low reset.
//  if_req     in   1          IF request; held with if_addr until if_gnt.
//  if_addr    in   BITS_ADDR  IF byte address (PC).
//  if_gnt     out  1          IF request accepted this cycle (combinational).
//  if_rvalid  out  1          IF response valid, 1-cycle pulse.
//  if_rdata   out  32         IF read data (ROM word, existing byte order).
//  if_err     out  1          IF response is a misaligned error; if_rdata is 0.
//  dp_req     in   1          DP request; held with dp_addr until dp_gnt.
//  dp_addr    in   BITS_ADDR  DP byte address.
//  dp_gnt     out  1          DP request accepted this cycle.
//  dp_rvalid  out  1          DP response valid.
//  dp_rdata   out  32         DP read data.
//  dp_err     out  1          DP misaligned error.
//  rom_addr   out  BITS_ADDR  To ROM address input (PC); always registered.
//  rom_rdata  in   32         From ROM word output (combinational).
// BEHAVIOUR
//  - Reset: all gnt/rvalid/err low; rdata 0; rom_addr 0; starve_cnt 0; pipeline empty.
//  - Pipeline: accept in cycle N -> rom_addr = req addr in N+1; rom_rdata is sampled at
//    end of N+1; rvalid/rdata/err are visible in N+2. Latency 2. One accept per cycle.
//    Back-to-back accepts are fully pipelined. No backpressure on responses.
//  - Arbitration (combinational from reqs and starve_cnt):
//    - Only one req -> grant it.
//    - Both reqs and starve_cnt < STARVE_MAX -> grant IF; starve_cnt++.
//    - Both reqs and starve_cnt == STARVE_MAX -> grant DP; starve_cnt = 0.
//    - Any DP grant, or dp_req low -> starve_cnt = 0. starve_cnt saturates at STARVE_MAX.
//  - No req -> no grant; rom_addr holds its last value; stage-1 valid clears.
//  - Stage 1 regs: v1, own1 (IF/DP), err1, rom_addr.
//    Stage 2 regs: v2, own2, err2, rdata_q.
//  - Response steering: rvalid on own2's port only. The other port's rvalid stays 0.
//    rdata/err hold their last value on both ports when rvalid is 0.
//  - Error (CHECK_ALIGN=1, addr[1:0]!=0): request is granted normally.
//    err=1 and rdata=0 at N+2; rom_addr is not updated.
//  - Wrap: aligned addresses never cross the top word. With CHECK_ALIGN=0, a ROM
//    byte-index wrap past 2**BITS_ADDR-1 is passed through unmodified.
//  - Async reset mid-operation: in-flight accepts are dropped, with no rvalid after
//    release. The first accept after release sees starve_cnt = 0.
//  - A req dropped before its grant is a protocol violation; the bench asserts on it.
// STRUCTURE
//  - Package rom_arb_pkg: owner_t {OWN_IF=0, OWN_DP=1}; localparam STARVE_W=4.
//  - Sub-module rom_arb_pick: combinational grant and starve_cnt next-state logic.
//    The top holds the two pipeline stages and the steering.
//  - Target 150-250 lines in total.
// TESTING
//  1. Reset, then IF only: if_addr 0x00, 0x04, 0x08 on consecutive cycles.
//     Expect rvalid on 3 consecutive cycles starting at N+2, words from ROM[0..11].
//  2. DP only, dp_addr 0xFC: dp_rvalid at N+2 with bytes ROM[FC..FF]; if_rvalid stays 0.
//  3. Both reqs held for 10 cycles, STARVE_MAX=4.
//     Expect grant pattern IF,IF,IF,IF,DP,IF,IF,IF,IF,DP.
//  4. if_addr 0x05 with CHECK_ALIGN=1: if_err=1, if_rdata=0 at N+2; rom_addr unchanged.
//     Repeat with CHECK_ALIGN=0: data from ROM[5..8], err=0.
//  5. Accept at N, assert rst_n low in N+1 for 1 cycle.
//     Expect no rvalid ever, all outputs 0, and normal operation after release.
//  6. Alternate single-cycle IF/DP reqs every cycle.
//     Expect each response on the correct port with the correct owner.
//     No cross-port data is ever observed.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
//   Shared types and constants for the ROM fetch arbiter.
//   owner_t   : identifies which requester owns an in-flight ROM read.
//   STARVE_W  : width of the DP starvation counter (supports STARVE_MAX 1..15).
//   misaligned: word-alignment check used at accept time.
// ---------------------------------------------------------------------------
package rom_arb_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DP = 1'b1
   } owner_t;

   localparam int STARVE_W = 4;

   // A word request is misaligned when either of the two byte-offset bits is set,
   // but only when alignment checking is enabled for this instance.
   function automatic logic misaligned(input logic [1:0] lsb, input logic check);
      return check && (lsb != 2'b00);
   endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// ---------------------------------------------------------------------------
// rom_arb_pick
//   Combinational grant selection between the instruction-fetch port (IF) and
//   the data-read port (DP), plus the next value of the DP starvation counter.
//   IF wins conflicts until DP has lost STARVE_MAX conflicts in a row; DP then
//   wins the next conflict and the counter restarts.
// Ports
//   if_req, dp_req   in   requests from the two ports
//   starve_cnt       in   current count of consecutive DP conflict losses
//   if_gnt, dp_gnt   out  one-hot (or zero) grant for this cycle
//   starve_nxt       out  counter value to register at the end of the cycle
// ---------------------------------------------------------------------------
module rom_arb_pick
   import rom_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                if_req,
   input  logic                dp_req,
   input  logic [STARVE_W-1:0] starve_cnt,
   output logic                if_gnt,
   output logic                dp_gnt,
   output logic [STARVE_W-1:0] starve_nxt
);

   localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

   always_comb begin
      if_gnt     = 1'b0;
      dp_gnt     = 1'b0;
      starve_nxt = '0;
      if (if_req && dp_req) begin
         if (starve_cnt >= SMAX) begin
            dp_gnt = 1'b1;
         end else begin
            // Counter never exceeds SMAX, so this increment saturates naturally.
            if_gnt     = 1'b1;
            starve_nxt = starve_cnt + 4'd1;
         end
      end else if (if_req) begin
         // DP not requesting: nothing is being starved.
         if_gnt = 1'b1;
      end else if (dp_req) begin
         dp_gnt = 1'b1;
      end
   end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// rom_fetch_arbiter
//   Shares one combinational 32-bit ROM read port between instruction fetch (IF)
//   and a data-read port (DP). One request is accepted per cycle; the ROM address
//   is registered in stage 1, the ROM word is captured in stage 2 and presented
//   with a one-cycle rvalid pulse on the owning port (latency 2, fully pipelined).
//
//   Handshake: a port raises req with a stable addr and holds both until it sees
//   gnt high in the same cycle; req&gnt is the accept. Responses have no
//   backpressure: rvalid is a single-cycle pulse that must be consumed.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr/if_gnt       IF request, byte address, accept
//   if_rvalid/if_rdata/if_err   IF response pulse, data, misaligned flag
//   dp_req/dp_addr/dp_gnt       DP request, byte address, accept
//   dp_rvalid/dp_rdata/dp_err   DP response pulse, data, misaligned flag
//   rom_addr                    registered ROM address
//   rom_rdata                   combinational ROM word
// ---------------------------------------------------------------------------
module rom_fetch_arbiter
   import rom_arb_pkg::*;
#(
   parameter int BITS_ADDR   = 8,
   parameter int STARVE_MAX  = 4,
   parameter int CHECK_ALIGN = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 if_req,
   input  logic [BITS_ADDR-1:0] if_addr,
   output logic                 if_gnt,
   output logic                 if_rvalid,
   output logic [31:0]          if_rdata,
   output logic                 if_err,
   input  logic                 dp_req,
   input  logic [BITS_ADDR-1:0] dp_addr,
   output logic                 dp_gnt,
   output logic                 dp_rvalid,
   output logic [31:0]          dp_rdata,
   output logic                 dp_err,
   output logic [BITS_ADDR-1:0] rom_addr,
   input  logic [31:0]          rom_rdata
);

   localparam logic CHK = (CHECK_ALIGN != 0);

   logic [STARVE_W-1:0]  starve_cnt;
   logic [STARVE_W-1:0]  starve_nxt;

   // Accept-side selection
   logic                 acc;
   owner_t               acc_own;
   logic [BITS_ADDR-1:0] acc_addr;
   logic                 acc_err;

   // Stage 1: address phase
   logic                 v1;
   owner_t               own1;
   logic                 err1;

   // Stage 2: response phase, data/err held per port so neither port ever
   // shows the other port's data.
   logic                 v2;
   owner_t               own2;
   logic [31:0]          if_rdata_q;
   logic [31:0]          dp_rdata_q;
   logic                 if_err_q;
   logic                 dp_err_q;

   rom_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .if_req     (if_req),
      .dp_req     (dp_req),
      .starve_cnt (starve_cnt),
      .if_gnt     (if_gnt),
      .dp_gnt     (dp_gnt),
      .starve_nxt (starve_nxt)
   );

   always_comb begin
      acc      = if_gnt | dp_gnt;
      acc_own  = dp_gnt ? OWN_DP : OWN_IF;
      acc_addr = dp_gnt ? dp_addr : if_addr;
      acc_err  = misaligned(acc_addr[1:0], CHK);
   end

   // Stage 1. A misaligned accept leaves rom_addr alone so the ROM is not
   // driven with an address that will never be consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         v1         <= 1'b0;
         own1       <= OWN_IF;
         err1       <= 1'b0;
         rom_addr   <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         v1         <= acc;
         if (acc) begin
            own1 <= acc_own;
            err1 <= acc_err;
            if (!acc_err) begin
               rom_addr <= acc_addr;
            end
         end
      end
   end

   // Stage 2. rom_rdata reflects rom_addr during stage 1 and is captured here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2         <= 1'b0;
         own2       <= OWN_IF;
         if_rdata_q <= '0;
         dp_rdata_q <= '0;
         if_err_q   <= 1'b0;
         dp_err_q   <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            own2 <= own1;
            if (own1 == OWN_IF) begin
               if_rdata_q <= err1 ? 32'd0 : rom_rdata;
               if_err_q   <= err1;
            end else begin
               dp_rdata_q <= err1 ? 32'd0 : rom_rdata;
               dp_err_q   <= err1;
            end
         end
      end
   end

   always_comb begin
      if_rvalid = v2 && (own2 == OWN_IF);
      dp_rvalid = v2 && (own2 == OWN_DP);
      if_rdata  = if_rdata_q;
      dp_rdata  = dp_rdata_q;
      if_err    = if_err_q;
      dp_err    = dp_err_q;
   end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
module tb_rom_fetch_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       if_req;
  logic [7:0] if_addr;
  logic       dp_req;
  logic [7:0] dp_addr;

  // dut0: CHECK_ALIGN=1, dut1: CHECK_ALIGN=0
  logic        if_gnt0, if_rvalid0, if_err0, dp_gnt0, dp_rvalid0, dp_err0;
  logic [31:0] if_rdata0, dp_rdata0, rom_rdata0;
  logic [7:0]  rom_addr0;
  logic        if_gnt1, if_rvalid1, if_err1, dp_gnt1, dp_rvalid1, dp_err1;
  logic [31:0] if_rdata1, dp_rdata1, rom_rdata1;
  logic [7:0]  rom_addr1;

  // ---------------- ROM model (little-endian byte order) ----------------
  function automatic logic [7:0] rom_byte(input logic [7:0] i);
    logic [7:0] r;
    r = i * 8'd37 + 8'd11;
    return r;
  endfunction

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {rom_byte(a + 8'd3), rom_byte(a + 8'd2), rom_byte(a + 8'd1), rom_byte(a)};
  endfunction

  assign rom_rdata0 = rom_word(rom_addr0);
  assign rom_rdata1 = rom_word(rom_addr1);

  rom_fetch_arbiter #(.BITS_ADDR(8), .STARVE_MAX(4), .CHECK_ALIGN(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt0), .if_rvalid(if_rvalid0),
    .if_rdata(if_rdata0), .if_err(if_err0),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_gnt(dp_gnt0), .dp_rvalid(dp_rvalid0),
    .dp_rdata(dp_rdata0), .dp_err(dp_err0),
    .rom_addr(rom_addr0), .rom_rdata(rom_rdata0)
  );

  rom_fetch_arbiter #(.BITS_ADDR(8), .STARVE_MAX(4), .CHECK_ALIGN(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1),
    .if_rdata(if_rdata1), .if_err(if_err1),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_gnt(dp_gnt1), .dp_rvalid(dp_rvalid1),
    .dp_rdata(dp_rdata1), .dp_err(dp_err1),
    .rom_addr(rom_addr1), .rom_rdata(rom_rdata1)
  );

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;
  int cyc;

  typedef struct {
    int          due;
    logic        own;   // 0 = IF, 1 = DP
    logic        err;
    logic [31:0] data;
  } rsp_t;
  rsp_t rsp_q[$];

  logic [31:0] last_if_data, last_dp_data;
  logic        last_if_err, last_dp_err;
  logic [7:0]  exp_rom_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- protocol monitor: req must be held until gnt ----------------
  logic       pend_if, pend_dp;
  logic [7:0] pend_if_addr, pend_dp_addr;
  initial begin
    pend_if = 1'b0;
    pend_dp = 1'b0;
    pend_if_addr = '0;
    pend_dp_addr = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_if = 1'b0;
      pend_dp = 1'b0;
    end else begin
      if (pend_if) chk("if_req_held", {if_req, if_addr}, {1'b1, pend_if_addr});
      if (pend_dp) chk("dp_req_held", {dp_req, dp_addr}, {1'b1, pend_dp_addr});
      pend_if      = if_req && !if_gnt0;
      pend_if_addr = if_addr;
      pend_dp      = dp_req && !dp_gnt0;
      pend_dp_addr = dp_addr;
    end
  end

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic ir, input logic [7:0] ia, input logic dr, input logic [7:0] da,
                      input logic eig, input logic edg);
    logic       exp_iv, exp_dv, e;
    logic [7:0] a;
    rsp_t       r;
    if_req  = ir;
    if_addr = ia;
    dp_req  = dr;
    dp_addr = da;
    #3;
    chk("if_gnt", if_gnt0, eig);
    chk("dp_gnt", dp_gnt0, edg);
    chk("rom_addr", rom_addr0, exp_rom_addr);
    exp_iv = 1'b0;
    exp_dv = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (r.own) begin
        exp_dv = 1'b1;
        last_dp_data = r.data;
        last_dp_err  = r.err;
      end else begin
        exp_iv = 1'b1;
        last_if_data = r.data;
        last_if_err  = r.err;
      end
    end
    chk("if_rvalid", if_rvalid0, exp_iv);
    chk("dp_rvalid", dp_rvalid0, exp_dv);
    chk("if_rdata", if_rdata0, last_if_data);
    chk("dp_rdata", dp_rdata0, last_dp_data);
    chk("if_err", if_err0, last_if_err);
    chk("dp_err", dp_err0, last_dp_err);
    if (eig || edg) begin
      a = edg ? da : ia;
      e = (a[1:0] != 2'b00);
      rsp_q.push_back('{cyc + 2, edg, e, e ? 32'd0 : rom_word(a)});
      if (!e) exp_rom_addr = a;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_rvalid"}, if_rvalid0, 0);
    chk({tag, "_dp_rvalid"}, dp_rvalid0, 0);
    chk({tag, "_if_rdata"},  if_rdata0,  0);
    chk({tag, "_dp_rdata"},  dp_rdata0,  0);
    chk({tag, "_if_err"},    if_err0,    0);
    chk({tag, "_dp_err"},    dp_err0,    0);
    chk({tag, "_rom_addr"},  rom_addr0,  0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ir;
    logic [7:0] ia;
    logic       dr;
    logic [7:0] da;
    logic       eig;
    logic       edg;
  } vec_t;
  vec_t vecs[16];

  logic [9:0] dp_pat;
  logic [7:0] ia, da, sav;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    last_if_data = '0;
    last_dp_data = '0;
    last_if_err  = 1'b0;
    last_dp_err  = 1'b0;
    exp_rom_addr = '0;

    // IF stream, DP at top word, then alternating single-cycle IF/DP
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'hFC, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'h14, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h24, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 8'h18, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h28, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    // reset
    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    dp_req  = 1'b0;
    dp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_if_gnt", if_gnt0, 0);
    chk("reset_dp_gnt", dp_gnt0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table: tests 1, 2, 6
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].da, vecs[i].eig, vecs[i].edg);
    end

    // test 3: both held 10 cycles, DP wins on the 5th and 10th
    dp_pat = 10'b10_0001_0000;
    ia = 8'h80;
    da = 8'h40;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ia, 1'b1, da, !dp_pat[i], dp_pat[i]);
      if (dp_pat[i]) da = da + 8'd4;
      else           ia = ia + 8'd4;
    end
    step(1'b1, ia, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // test 4: misaligned 0x05 (dut0 errors, dut1 passes through)
    sav = rom_addr0;
    step(1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("mis_rom_addr_hold", rom_addr0, sav);
    chk("mis_rom_addr_pass", rom_addr1, 8'h05);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("noalign_rvalid", if_rvalid1, 1);
    chk("noalign_rdata", if_rdata1, rom_word(8'h05));
    chk("noalign_err", if_err1, 0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // misaligned near top: dut1 byte index wraps FE,FF,00,01
    step(1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_rvalid", dp_rvalid1, 1);
    chk("wrap_rdata", dp_rdata1, {rom_byte(8'h01), rom_byte(8'h00), rom_byte(8'hFF), rom_byte(8'hFE)});
    chk("wrap_err", dp_err1, 0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // test 5: build starve_cnt to 3, accept at N, reset during N+1
    step(1'b1, 8'h30, 1'b1, 8'h50, 1'b1, 1'b0);
    step(1'b1, 8'h34, 1'b1, 8'h50, 1'b1, 1'b0);
    step(1'b1, 8'h38, 1'b1, 8'h50, 1'b1, 1'b0);
    if_req = 1'b0;
    dp_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rsp_q.delete();
    last_if_data = '0;
    last_dp_data = '0;
    last_if_err  = 1'b0;
    last_dp_err  = 1'b0;
    exp_rom_addr = '0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    dp_pat = 10'b00_0001_0000;
    ia = 8'h60;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ia, 1'b1, 8'h70, !dp_pat[i], dp_pat[i]);
      if (!dp_pat[i]) ia = ia + 8'd4;
    end
    step(1'b1, ia, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    chk("queue_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
